// File: rtl/serial_result_receiver.sv
// Serial result receiver: deserializes calculator result frames (data byte
// followed by flag nibble, MSB first), validates frame length, buffers good
// frames in a show-ahead FIFO and presents them on a valid/ready port.
module serial_result_receiver #(
  parameter  int DATA_W     = 8,
  parameter  int FLAG_W     = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SampleEn,
  input  logic              Din,
  input  logic              FrameValid,
  input  logic              RxReady,
  input  logic              ErrClr,
  output logic              RxValid,
  output logic [DATA_W-1:0] RxData,
  output logic [FLAG_W-1:0] RxFlag,
  output logic              FrameErr,
  output logic              Overrun,
  output logic [LVL_W-1:0]  Level
);

  localparam int FRAME_W = DATA_W + FLAG_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t                               state, state_n;
  logic [FRAME_W-1:0]                   sr, sr_n;
  logic [CNT_W-1:0]                     cnt, cnt_n;
  logic                                 fv_q, fv_rise;
  logic                                 push, pop, full;
  logic                                 ferr_set, ovr_set;
  logic [FIFO_DEPTH-1:0][FRAME_W-1:0]   mem;
  logic [AW-1:0]                        wptr, rptr, rptr_p1;
  logic [LVL_W-1:0]                     level_n;
  logic [FRAME_W-1:0]                   head;

  assign fv_rise = FrameValid & ~fv_q;
  assign pop     = RxValid & RxReady;
  assign full    = (Level == LVL_W'(FIFO_DEPTH));
  assign rptr_p1 = rptr + AW'(1);
  assign RxValid = (Level != '0);
  assign RxData  = head[FRAME_W-1:FLAG_W];
  assign RxFlag  = head[FLAG_W-1:0];

  // FrameValid history; resets high so a frame already running at reset
  // release is not mistaken for a fresh start.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) fv_q <= 1'b1;
    else      fv_q <= FrameValid;
  end

  // Frame FSM state, shift register and bit counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  // Frame FSM next state: sampling, length check, push / error decisions.
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    push     = 1'b0;
    ferr_set = 1'b0;
    ovr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (fv_rise) begin
          state_n = SHIFT;
          cnt_n   = '0;
          if (SampleEn) begin
            sr_n  = {sr[FRAME_W-2:0], Din};
            cnt_n = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (!FrameValid) begin
          state_n = IDLE;
          if (cnt == CNT_W'(FRAME_W)) begin
            // a same-edge pop frees the slot this frame needs
            if (!full || pop) push    = 1'b1;
            else              ovr_set = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else if (SampleEn) begin
          if (cnt == CNT_W'(FRAME_W)) begin
            ferr_set = 1'b1;
            state_n  = DRAIN;
          end else begin
            sr_n  = {sr[FRAME_W-2:0], Din};
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!FrameValid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since Level gates visibility.
  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= sr;
  end

  // Occupancy after this edge.
  always_comb begin
    level_n = Level;
    case ({push, pop})
      2'b10:   level_n = Level + LVL_W'(1);
      2'b01:   level_n = Level - LVL_W'(1);
      default: level_n = Level;
    endcase
  end

  // Pointers, level and registered head entry (held while empty).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      Level <= '0;
      head  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr_p1;
      Level <= level_n;
      if (level_n != '0 && (pop || Level == '0))
        head <= (Level > LVL_W'(1)) ? mem[rptr_p1] : sr;
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (ferr_set)    FrameErr <= 1'b1;
      else if (ErrClr) FrameErr <= 1'b0;
      if (ovr_set)     Overrun  <= 1'b1;
      else if (ErrClr) Overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_result_receiver.sv
// Bench for serial_result_receiver: vector table, hand sequences for the
// multi-cycle corners, and randomized frames against a frame-level model.
module tb_serial_result_receiver;

  localparam int DEPTH    = 4;
  localparam int EV_NONE  = 0;
  localparam int EV_LONG  = 1;
  localparam int EV_SHORT = 2;
  localparam int EV_GOOD  = 3;

  logic       Clk = 1'b0, Rst = 1'b0, SampleEn = 1'b0, Din = 1'b0;
  logic       FrameValid = 1'b0, RxReady = 1'b0, ErrClr = 1'b0;
  logic       RxValid, FrameErr, Overrun;
  logic [7:0] RxData;
  logic [3:0] RxFlag;
  logic [2:0] Level;

  serial_result_receiver #(.DATA_W(8), .FLAG_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .SampleEn(SampleEn), .Din(Din),
    .FrameValid(FrameValid), .RxReady(RxReady), .ErrClr(ErrClr),
    .RxValid(RxValid), .RxData(RxData), .RxFlag(RxFlag),
    .FrameErr(FrameErr), .Overrun(Overrun), .Level(Level)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;

  // frame-level model: queue of accepted {data,flag} words plus sticky flags
  logic [11:0] mq[$];
  logic [11:0] m_head;
  logic        m_fe, m_ov;
  int          rdy_mode;   // 0 never, 1 always, 2 random, 3 only on frame end
  logic        clr_q;

  typedef struct {
    int          nbits;
    logic [11:0] word;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [3:0]  exp_f;
    logic        exp_fe;
    int          exp_lvl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", RxValid, mq.size() > 0);
    chk("level", Level, mq.size());
    chk("data", RxData, m_head[11:4]);
    chk("flag", RxFlag, m_head[3:0]);
    chk("frame_err", FrameErr, m_fe);
    chk("overrun", Overrun, m_ov);
  endtask

  // One clock: drive inputs, advance the model by the rules, compare.
  task automatic tick(input logic fv, input logic se, input logic d,
                      input int ev, input logic [11:0] w);
    logic rdy, pop, set_fe, set_ov;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = (ev == EV_GOOD);
    endcase
    FrameValid = fv; SampleEn = se; Din = d; RxReady = rdy; ErrClr = clr_q;
    pop    = (mq.size() > 0) && rdy;
    set_fe = (ev == EV_LONG) || (ev == EV_SHORT);
    set_ov = 1'b0;
    if (pop) void'(mq.pop_front());
    if (ev == EV_GOOD) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else                   set_ov = 1'b1;
    end
    m_fe = set_fe ? 1'b1 : (clr_q ? 1'b0 : m_fe);
    m_ov = set_ov ? 1'b1 : (clr_q ? 1'b0 : m_ov);
    if (mq.size() > 0) m_head = mq[0];
    @(posedge Clk);
    @(negedge Clk);
    clr_q = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, EV_NONE, 12'h0);
  endtask

  // Send nbits strobes MSB first from word, random gaps up to gap_max.
  task automatic send_frame(input int nbits, input logic [11:0] word, input int gap_max);
    int k, g;
    logic b;
    logic [11:0] sh;
    k = 0; sh = word;
    for (int i = 0; i < nbits; i++) begin
      g = $urandom_range(0, gap_max);
      for (int j = 0; j < g; j++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), EV_NONE, 12'h0);
      k++;
      b = sh[11]; sh = sh << 1;
      if (k > 12) b = 1'($urandom_range(0, 1));
      tick(1'b1, 1'b1, b, (k == 13) ? EV_LONG : EV_NONE, 12'h0);
    end
    g = $urandom_range(0, gap_max);
    for (int j = 0; j < g; j++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), EV_NONE, 12'h0);
    tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         (k == 12) ? EV_GOOD : ((k < 12) ? EV_SHORT : EV_NONE), word);
    g = $urandom_range(0, gap_max);
    for (int j = 0; j < g; j++) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), EV_NONE, 12'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, RxValid, 1'b0);
    chk({tag, "_data"}, RxData, 8'h00);
    chk({tag, "_flag"}, RxFlag, 4'h0);
    chk({tag, "_ferr"}, FrameErr, 1'b0);
    chk({tag, "_ovr"}, Overrun, 1'b0);
    chk({tag, "_level"}, Level, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] exp_pop[4];
    vecs[0] = '{12, 12'h0A0, 1'b1, 8'h0A, 4'h0, 1'b0, 1};
    vecs[1] = '{12, 12'hFF5, 1'b1, 8'hFF, 4'h5, 1'b0, 1};
    vecs[2] = '{12, 12'h3C9, 1'b1, 8'h3C, 4'h9, 1'b0, 1};
    vecs[3] = '{ 7, 12'hABC, 1'b0, 8'h00, 4'h0, 1'b1, 0};
    vecs[4] = '{13, 12'h123, 1'b0, 8'h00, 4'h0, 1'b1, 0};
    vecs[5] = '{12, 12'h070, 1'b1, 8'h07, 4'h0, 1'b0, 1};
    vecs[6] = '{ 1, 12'h800, 1'b0, 8'h00, 4'h0, 1'b1, 0};
    vecs[7] = '{12, 12'h801, 1'b1, 8'h80, 4'h1, 1'b0, 1};

    mq.delete(); m_head = '0; m_fe = 1'b0; m_ov = 1'b0; rdy_mode = 0; clr_q = 1'b0;

    // reset state
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b1;
    idle(2);

    // vector table: one frame each, host stalled, then drain and clear
    for (int i = 0; i < 8; i++) begin
      rdy_mode = 0;
      send_frame(vecs[i].nbits, vecs[i].word, 1);
      chk("tbl_valid", RxValid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        chk("tbl_data", RxData, vecs[i].exp_d);
        chk("tbl_flag", RxFlag, vecs[i].exp_f);
      end
      chk("tbl_ferr", FrameErr, vecs[i].exp_fe);
      chk("tbl_level", Level, vecs[i].exp_lvl);
      rdy_mode = 1; clr_q = 1'b1;
      idle(1);
      rdy_mode = 0;
    end

    // single frame with host ready: one-cycle valid pulse
    rdy_mode = 1;
    send_frame(12, 12'h0A0, 0);
    chk("pulse_valid", RxValid, 1'b1);
    chk("pulse_data", RxData, 8'h0A);
    idle(1);
    chk("pulse_gone", RxValid, 1'b0);
    chk("pulse_level", Level, 3'd0);

    // back-to-back frames into a stalled host: fifth one overruns
    rdy_mode = 0;
    send_frame(12, 12'h0D0, 1);
    send_frame(12, 12'h090, 1);
    send_frame(12, 12'h120, 1);
    send_frame(12, 12'h050, 1);
    send_frame(12, 12'h001, 1);
    chk("ovr_level", Level, 3'd4);
    chk("ovr_flag", Overrun, 1'b1);
    exp_pop = '{8'h0D, 8'h09, 8'h12, 8'h05};
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ovr_pop_order", RxData, exp_pop[i]);
      idle(1);
    end
    chk("ovr_drained", Level, 3'd0);
    rdy_mode = 0; clr_q = 1'b1;
    idle(1);
    chk("ovr_cleared", Overrun, 1'b0);

    // full FIFO with a pop on the push edge: push accepted, no overrun
    send_frame(12, 12'h110, 1);
    send_frame(12, 12'h120, 1);
    send_frame(12, 12'h130, 1);
    send_frame(12, 12'h140, 1);
    chk("full_level", Level, 3'd4);
    rdy_mode = 3;
    send_frame(12, 12'h400, 0);
    chk("simul_level", Level, 3'd4);
    chk("simul_ovr", Overrun, 1'b0);
    exp_pop = '{8'h12, 8'h13, 8'h14, 8'h40};
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      chk("simul_pop_order", RxData, exp_pop[i]);
      idle(1);
    end
    rdy_mode = 0;

    // short frame, then good frame still received, then ErrClr
    send_frame(7, 12'hFFF, 1);
    chk("short_ferr", FrameErr, 1'b1);
    chk("short_level", Level, 3'd0);
    send_frame(12, 12'h070, 1);
    chk("after_short_level", Level, 3'd1);
    chk("after_short_data", RxData, 8'h07);
    chk("after_short_ferr", FrameErr, 1'b1);
    rdy_mode = 1; clr_q = 1'b1;
    idle(1);
    chk("errclr_ferr", FrameErr, 1'b0);
    rdy_mode = 0;

    // reset in the middle of a frame
    send_frame(12, 12'h5A3, 1);
    send_frame(3, 12'hE00, 0);
    tick(1'b1, 1'b0, 1'b0, EV_NONE, 12'h0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), EV_NONE, 12'h0);
    Rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mq.delete(); m_head = '0; m_fe = 1'b0; m_ov = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), EV_NONE, 12'h0);
    tick(1'b0, 1'b0, 1'b0, EV_NONE, 12'h0);
    chk("tail_ignored", Level, 3'd0);
    send_frame(12, 12'hC36, 1);
    chk("post_reset_valid", RxValid, 1'b1);
    chk("post_reset_data", RxData, 8'hC3);
    chk("post_reset_flag", RxFlag, 4'h6);
    rdy_mode = 1;
    idle(1);

    // randomized frames, host and clears random
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int nb;
      if ($urandom_range(0, 9) < 7)   nb = 12;
      else if ($urandom_range(0, 1)) nb = $urandom_range(1, 11);
      else                            nb = $urandom_range(13, 15);
      clr_q = ($urandom_range(0, 7) == 0);
      send_frame(nb, 12'($urandom), 2);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
